// File: rtl/i2c_target_stretch.sv
// I2C write-only target with address ACK and post-ACK clock stretching toward the application.
// Optional macro I2C_GEN_CALL_EN: also ACK the general-call address byte 8'h00.
module i2c_target_stretch #(
    parameter logic [6:0] ADDR           = 7'h42,
    parameter int         STRETCH_CYCLES = 16,
    parameter int         SBITS          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       stall_in,
    output logic       scl_drive_low,
    output logic       sda_drive_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_STRETCH,
        ST_WAIT_STOP
    } state_t;

    localparam logic [SBITS-1:0] STRETCH_MIN = SBITS'(STRETCH_CYCLES);
    localparam logic [SBITS-1:0] CNT_MAX     = {SBITS{1'b1}};

    state_t           state_q, state_d;
    logic             scl_meta_q, sda_meta_q;
    logic             scl_s_q, sda_s_q;
    logic             scl_prev_q, sda_prev_q;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [SBITS-1:0] cnt_q, cnt_d;
    logic             scl_drv_q, scl_drv_d;
    logic             sda_drv_q, sda_drv_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             addr_match_q, addr_match_d;
    logic             busy_q, busy_d;

    logic       scl_rise, scl_fall, start_det, stop_det, addr_hit;
    logic [7:0] byte_in;

    assign scl_rise  = scl_s_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s_q & scl_prev_q;
    assign start_det = scl_s_q & sda_prev_q & ~sda_s_q;
    assign stop_det  = scl_s_q & ~sda_prev_q & sda_s_q;
    assign byte_in   = {shift_q[6:0], sda_s_q};

`ifdef I2C_GEN_CALL_EN
    assign addr_hit = ((byte_in[7:1] == ADDR) && !byte_in[0]) || (byte_in == 8'h00);
`else
    assign addr_hit = (byte_in[7:1] == ADDR) && !byte_in[0];
`endif

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        cnt_d        = cnt_q;
        scl_drv_d    = scl_drv_q;
        sda_drv_d    = sda_drv_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        addr_match_d = addr_match_q;
        busy_d       = busy_q;

        // STOP outranks everything, including a coincident SCL fall.
        if (stop_det) begin
            state_d      = ST_IDLE;
            scl_drv_d    = 1'b0;
            sda_drv_d    = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
        end else if (start_det) begin
            state_d      = ST_ADDR;
            bit_cnt_d    = 3'd0;
            scl_drv_d    = 1'b0;
            sda_drv_d    = 1'b0;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK, ST_RX_ACK: begin
                    if (scl_fall) begin
                        scl_drv_d = 1'b1;
                        sda_drv_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_STRETCH;
                        if (state_q == ST_ADDR_ACK) begin
                            addr_match_d = 1'b1;
                        end
                    end
                end
                ST_STRETCH: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Hold SCL until the minimum elapses and the application is ready,
                    // then keep SDA low through the ACK clock high phase.
                    if (scl_drv_q) begin
                        if ((cnt_q >= STRETCH_MIN) && !stall_in) begin
                            scl_drv_d = 1'b0;
                        end
                    end else if (scl_fall) begin
                        sda_drv_d = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_RX;
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            state_d    = ST_RX_ACK;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            scl_meta_q   <= 1'b1;
            sda_meta_q   <= 1'b1;
            scl_s_q      <= 1'b1;
            sda_s_q      <= 1'b1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            cnt_q        <= '0;
            scl_drv_q    <= 1'b0;
            sda_drv_q    <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            scl_meta_q   <= scl_in;
            sda_meta_q   <= sda_in;
            scl_s_q      <= scl_meta_q;
            sda_s_q      <= sda_meta_q;
            scl_prev_q   <= scl_s_q;
            sda_prev_q   <= sda_s_q;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            cnt_q        <= cnt_d;
            scl_drv_q    <= scl_drv_d;
            sda_drv_q    <= sda_drv_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
        end
    end

    assign scl_drive_low = scl_drv_q;
    assign sda_drive_low = sda_drv_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign addr_match    = addr_match_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_target_stretch.sv
// Bench for i2c_target_stretch: an open-drain bus master model with stretch detection,
// and a transaction-level reference model of ACK / receive / stretch behaviour.
module tb_i2c_target_stretch;

    localparam int SC = 16;
    localparam int Q  = 4;
    localparam int H  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m, stall_in;
    logic       scl_line, sda_line;
    logic       scl_drive_low, sda_drive_low, rx_valid, addr_match, busy;
    logic [7:0] rx_data;

    int n_pass  = 0;
    int n_total = 0;

    int         run_len  = 0;
    int         runs[$];
    int         rxv_cnt  = 0;
    logic [7:0] rx_log[$];
    int         sda_drv_cycles = 0;

    assign scl_line = scl_m & ~scl_drive_low;
    assign sda_line = sda_m & ~sda_drive_low;

    always #5 clk = ~clk;

    i2c_target_stretch #(.ADDR(7'h42), .STRETCH_CYCLES(SC), .SBITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .scl_in       (scl_line),
        .sda_in       (sda_line),
        .stall_in     (stall_in),
        .scl_drive_low(scl_drive_low),
        .sda_drive_low(sda_drive_low),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .addr_match   (addr_match),
        .busy         (busy)
    );

    initial begin
        forever begin
            @(negedge clk);
            if (scl_drive_low === 1'b1) run_len++;
            else if (run_len > 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end
            if (rx_valid === 1'b1) begin
                rxv_cnt++;
                rx_log.push_back(rx_data);
            end
            if (sda_drive_low === 1'b1) sda_drv_cycles++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
        $fatal(1);
    end

    // Reference rule: a write to our 7-bit address (or general call when enabled) is ACKed.
    function automatic logic model_ack(input logic [7:0] a);
        logic hit;
        hit = (a[7:1] == 7'h42) && (a[0] == 1'b0);
`ifdef I2C_GEN_CALL_EN
        if (a == 8'h00) hit = 1'b1;
`endif
        return hit;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_scl();
        scl_m = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (scl_line === 1'b1) break;
            @(negedge clk);
        end
        if (scl_line !== 1'b1) begin
            n_total++;
            $display("FAIL scl_release_timeout: scl=%b required 1", scl_line);
        end
    endtask

    task automatic i2c_start();
        clks(Q); sda_m = 1'b1;
        clks(Q); release_scl();
        clks(H); sda_m = 1'b0;
        clks(H); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        clks(Q); sda_m = 1'b0;
        clks(Q); release_scl();
        clks(H); sda_m = 1'b1;
        clks(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            clks(Q); sda_m = b[i];
            clks(Q); release_scl();
            clks(H); scl_m = 1'b0;
        end
        clks(Q); sda_m = 1'b1;
        clks(Q); release_scl();
        clks(Q); ack = (sda_line === 1'b0);
        clks(Q); scl_m = 1'b0;
    endtask

    task automatic clear_mon();
        runs.delete();
        rx_log.delete();
        rxv_cnt        = 0;
        sda_drv_cycles = 0;
    endtask

    task automatic run_xfer(input string nm, input logic [7:0] a, input int n, input logic [31:0] payload);
        logic ack, exp_ack;
        logic [7:0] d;
        exp_ack = model_ack(a);
        clear_mon();
        i2c_start();
        write_byte(a, ack);
        n_total++;
        if (ack !== exp_ack) $display("FAIL %s addr_ack: got %b required %b (addr %h)", nm, ack, exp_ack, a);
        else n_pass++;
        n_total++;
        if (addr_match !== exp_ack) $display("FAIL %s addr_match: got %b required %b", nm, addr_match, exp_ack);
        else n_pass++;
        for (int i = 0; i < n; i++) begin
            d = payload[8*i +: 8];
            write_byte(d, ack);
            n_total++;
            if (ack !== exp_ack) $display("FAIL %s data_ack[%0d]: got %b required %b", nm, i, ack, exp_ack);
            else n_pass++;
        end
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s busy_before_stop: got %b required 1", nm, busy);
        else n_pass++;
        i2c_stop();
        n_total++;
        if (busy !== 1'b0 || addr_match !== 1'b0)
            $display("FAIL %s after_stop: busy=%b addr_match=%b required 0 0", nm, busy, addr_match);
        else n_pass++;
        n_total++;
        if (rxv_cnt !== (exp_ack ? n : 0)) $display("FAIL %s rx_valid_count: got %0d required %0d", nm, rxv_cnt, exp_ack ? n : 0);
        else n_pass++;
        if (exp_ack) begin
            for (int i = 0; i < n && i < rx_log.size(); i++) begin
                n_total++;
                if (rx_log[i] !== payload[8*i +: 8]) $display("FAIL %s rx_data[%0d]: got %h required %h", nm, i, rx_log[i], payload[8*i +: 8]);
                else n_pass++;
            end
        end else begin
            n_total++;
            if (sda_drv_cycles != 0) $display("FAIL %s sda_driven_on_nack: got %0d cycles required 0", nm, sda_drv_cycles);
            else n_pass++;
        end
        n_total++;
        if (runs.size() != (exp_ack ? n + 1 : 0)) $display("FAIL %s stretch_count: got %0d required %0d", nm, runs.size(), exp_ack ? n + 1 : 0);
        else n_pass++;
        foreach (runs[i]) begin
            n_total++;
            if (runs[i] < SC || runs[i] > SC + 2) $display("FAIL %s stretch_len[%0d]: got %0d required %0d..%0d", nm, i, runs[i], SC, SC + 2);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; stall_in = 1'b0;
        clks(4);
        n_total++;
        if ({scl_drive_low, sda_drive_low, rx_valid, addr_match, busy, rx_data} !== 13'h0)
            $display("FAIL reset_outputs: got %b%b%b%b%b %h required all 0", scl_drive_low, sda_drive_low, rx_valid, addr_match, busy, rx_data);
        else n_pass++;
        rst = 1'b0;
        clks(4);
        n_total++;
        if (busy !== 1'b0 || scl_drive_low !== 1'b0) $display("FAIL idle_after_reset: busy=%b scl_drv=%b required 0 0", busy, scl_drive_low);
        else n_pass++;
    endtask

    task automatic test_basic();
        run_xfer("basic_42_a5", 8'h84, 1, 32'h0000_00A5);
        n_total++;
        if (rx_data !== 8'hA5) $display("FAIL basic_rx_data: got %h required a5", rx_data);
        else n_pass++;
    endtask

    task automatic test_mismatch();
        run_xfer("mismatch_43", 8'h86, 1, 32'h0000_0077);
    endtask

    task automatic test_read();
        run_xfer("read_42", 8'h85, 0, 32'h0);
    endtask

    task automatic test_general_call();
        run_xfer("general_call", 8'h00, 1, 32'h0000_0011);
    endtask

    task automatic test_stall();
        logic ack0, ack1;
        bit seen;
        clear_mon();
        i2c_start();
        write_byte(8'h84, ack0);
        stall_in = 1'b1;
        fork
            write_byte(8'h5A, ack1);
            begin
                seen = 1'b0;
                for (int i = 0; i < 1000; i++) begin
                    if (scl_drive_low === 1'b1) begin seen = 1'b1; break; end
                    @(negedge clk);
                end
                n_total++;
                if (!seen) $display("FAIL stall_stretch_start: scl_drive_low=%b required 1", scl_drive_low);
                else n_pass++;
                clks(200);
                n_total++;
                if (scl_drive_low !== 1'b1) $display("FAIL stall_hold_200: got %b required 1", scl_drive_low);
                else n_pass++;
                stall_in = 1'b0;
                @(posedge clk); #1;
                n_total++;
                if (scl_drive_low !== 1'b0) $display("FAIL stall_release_1clk: got %b required 0", scl_drive_low);
                else n_pass++;
            end
        join
        i2c_stop();
        n_total++;
        if (ack0 !== 1'b1 || ack1 !== 1'b1) $display("FAIL stall_acks: got %b %b required 1 1", ack0, ack1);
        else n_pass++;
        n_total++;
        if (runs.size() != 2 || runs[runs.size() - 1] < 200)
            $display("FAIL stall_run_len: runs=%0d last=%0d required 2 runs, last>=200", runs.size(), runs.size() > 0 ? runs[runs.size() - 1] : 0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic ack;
        clear_mon();
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h3C, ack);
        n_total++;
        if (rx_data !== 8'h3C) $display("FAIL rs_first_byte: got %h required 3c", rx_data);
        else n_pass++;
        i2c_start();
        n_total++;
        if (addr_match !== 1'b0 || busy !== 1'b1) $display("FAIL rs_after_restart: addr_match=%b busy=%b required 0 1", addr_match, busy);
        else n_pass++;
        write_byte(8'h84, ack);
        write_byte(8'h01, ack);
        i2c_stop();
        n_total++;
        if (rxv_cnt != 2 || rx_log.size() != 2 || rx_log[0] !== 8'h3C || rx_log[1] !== 8'h01)
            $display("FAIL rs_rx_sequence: count=%0d last=%h required 2 pulses 3c,01", rxv_cnt, rx_data);
        else n_pass++;
    endtask

    task automatic test_reset_in_stretch();
        logic ack;
        bit seen;
        i2c_start();
        fork
            write_byte(8'h84, ack);
            begin
                seen = 1'b0;
                for (int i = 0; i < 1000; i++) begin
                    if (scl_drive_low === 1'b1) begin seen = 1'b1; break; end
                    @(negedge clk);
                end
                clks(3);
                #2 rst = 1'b1;
                #1;
                n_total++;
                if (!seen || scl_drive_low !== 1'b0 || sda_drive_low !== 1'b0 || busy !== 1'b0)
                    $display("FAIL reset_in_stretch: seen=%b scl=%b sda=%b busy=%b required 1 0 0 0", seen, scl_drive_low, sda_drive_low, busy);
                else n_pass++;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        i2c_stop();
        n_total++;
        if (busy !== 1'b0 || addr_match !== 1'b0) $display("FAIL post_reset_idle: busy=%b addr_match=%b required 0 0", busy, addr_match);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [31:0] p;
        int          n;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0: a = 8'h84;
                1: a = 8'h86;
                2: a = 8'h85;
                default: a = 8'($urandom_range(0, 255));
            endcase
            n = $urandom_range(1, 3);
            p = $urandom;
            run_xfer("random", a, n, p);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_read();
        test_stall();
        test_back_to_back();
        test_reset_in_stretch();
        test_general_call();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2c_target_stretch.md
Name: i2c_target_stretch

Overview:
- I2C target (responder) front end. Counterpart of the team's stretch-aware master SCL/data clock generator.
- Decodes START/STOP, receives the address byte and write data bytes, and ACKs on address match.
- After every ACKed byte, holds SCL low (clock stretch) until the application is ready, which exercises the master's stretch detection.
- Sits between the open-drain pad cells and the application register file.

Parameters:
- ADDR, 7'h42, own 7-bit target address.
- STRETCH_CYCLES, 16, minimum clk cycles SCL is held low after each ACKed byte; 0 disables the minimum hold.
- SBITS, 8, width of the stretch counter. Must satisfy STRETCH_CYCLES < 2**SBITS.

Ports:
- clk  input  1  system clock, greater than 8x SCL rate.
- rst  input  1  asynchronous, active-high reset.
- scl_in  input  1  raw SCL from pad, asynchronous.
- sda_in  input  1  raw SDA from pad, asynchronous.
- stall_in  input  1  application not ready; extends the stretch while high.
- scl_drive_low  output  1  1 = pull SCL low (open-drain enable).
- sda_drive_low  output  1  1 = pull SDA low (open-drain enable).
- rx_data  output  8  last received data byte.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- addr_match  output  1  high from address ACK until STOP or repeated START.
- busy  output  1  high between START and STOP.

Behaviour:
- Reset (async):
  - State IDLE.
  - scl_drive_low = 0, sda_drive_low = 0, rx_data = 0, rx_valid = 0, addr_match = 0, busy = 0.
  - Synchronizers set to 1.
  - Reset mid-transfer releases both lines immediately, without waiting for a clock edge.
- Input conditioning:
  - scl_in and sda_in pass through 2-flop synchronizers: scl_s, sda_s.
  - Previous-sample registers give rise/fall strobes. Every decision uses synchronized values.
- Bus conditions:
  - START = sda_s falls while scl_s is 1.
  - STOP = sda_s rises while scl_s is 1.
  - STOP from any state goes to IDLE, releases both lines and clears busy and addr_match.
  - START in any state (including repeated START) goes to ADDR, sets busy, clears addr_match and the bit counter.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, STRETCH, WAIT_STOP.
  - ADDR: shift sda_s MSB-first on each scl_s rise; 3-bit counter. After the 8th bit, compare.
    - Match means byte[7:1] == ADDR and R/W = 0. Go to ADDR_ACK.
    - Otherwise (including reads) go to WAIT_STOP; lines are never driven.
  - ADDR_ACK / RX_ACK: on the next scl_s fall, assert sda_drive_low and scl_drive_low, then enter STRETCH. The stretch counter is loaded with 0.
  - STRETCH: counter increments each clk.
    - Release scl_drive_low on the first cycle where counter >= STRETCH_CYCLES and stall_in == 0.
    - The counter saturates; it does not wrap.
    - sda_drive_low stays asserted through the 9th SCL high.
    - On the following scl_s fall, release SDA and enter RX.
  - RX: shift 8 bits as in ADDR. On the 8th scl_s rise:
    - rx_data gets the byte.
    - rx_valid pulses on the same clk cycle.
    - Go to RX_ACK.
  - WAIT_STOP: ignore traffic until STOP or START.
- addr_match sets on entry to the address STRETCH.
- Outputs are registered. Line-drive latency from the qualifying synchronized edge is 1 clk, i.e. 3 clk from the pad.
- Simultaneous STOP and scl_s fall in the same cycle: STOP wins; lines are not driven.
- stall_in is ignored outside STRETCH.

Optional Feature:
- Macro: I2C_GEN_CALL_EN.
- Defined: address byte 8'h00 (general call, write) is also matched and ACKed. addr_match is asserted exactly as for own-address.
- Undefined: 8'h00 goes to WAIT_STOP like any mismatch.

Test Plan:
- Write addr 0x42, data 0xA5, STOP, stall_in = 0 → ACK (SDA low) on both 9th clocks; SCL held low ≥16 clk after each byte; rx_data = 0xA5; exactly one rx_valid pulse; busy falls at STOP.
- Address 0x43 write → no SDA or SCL drive for the whole transfer; rx_valid never pulses; addr_match = 0.
- Address 0x42 read (byte 0x85) → NACK, no stretch, WAIT_STOP until STOP.
- stall_in high for 200 clk during data stretch → SCL held low ≥200 clk; released 1 clk after stall_in falls.
- Repeated START after data byte 0x3C, then addr 0x42 and data 0x01 → rx_data goes 0x3C then 0x01; two rx_valid pulses.
- Assert rst while in STRETCH → scl_drive_low and sda_drive_low are 0 in the same cycle; busy = 0.
- With I2C_GEN_CALL_EN defined: address byte 0x00 → ACKed; addr_match = 1.
